alignment_sequencer: RTL and testbench
======================================

# alignment_sequencer

Sequencer that owns the 64-bit byte-rotation alignment network and uses it to pack a stream of variable-length, low-justified input chunks into dense 8-byte output words. Each cycle it chooses the network rotation (`aln_start`) from its current fill level and merges the rotated bytes into a holding register. It emits full words, and flushes a partial word on end-of-packet. It sits between the input buffer (valid/ready) and the output buffer (valid/ready); the network itself is combinational and is instantiated beside this block.

## Interface
- `DATA_WIDTH`, 64, datapath width; fixed at 64 (8 byte lanes, 3-bit rotation).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  64  input chunk; valid bytes occupy lanes 0..in_bytes-1.
- `in_bytes`  in  4  valid byte count, 0..8; values above 8 are treated as 8.
- `in_last`  in  1  chunk ends the packet.
- `in_valid`  in  1  input chunk present.
- `in_ready`  out  1  chunk accepted when in_valid & in_ready.
- `aln_in`  out  64  network data input; equals in_data.
- `aln_reverse`  out  1  network reverse control; driven 0.
- `aln_start`  out  3  network rotation amount; equals current fill.
- `aln_out`  in  64  network result: byte k = aln_in byte (k - aln_start) mod 8.
- `out_data`  out  64  packed word; unused lanes are 0.
- `out_bytes`  out  4  valid bytes in out_data, 1..8.
- `out_last`  out  1  final word of packet.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  output word consumed when out_valid & out_ready.

## Operation
- State: `fill` (0..7 bytes held in lanes 0..fill-1 of `hold`), FSM {RUN, FLUSH}, output register.
- Output register is free when `!out_valid | out_ready`.
- `in_ready = (state==RUN) & free`.
- On accept, with n = min(in_bytes,8) and total = fill+n, rotated bytes come from `aln_out`.
  - total<8 and !in_last: merge lanes fill..total-1 into hold; fill=total; no output.
  - total>=8: out word = hold lanes 0..fill-1 plus rotated lanes fill..7; out_bytes=8. Rotated lanes 0..total-9 become the new hold; fill=total-8.
  - in_last and total<=8: emit hold+chunk; out_bytes=total; out_last=1; fill=0. If total==0, emit nothing.
  - in_last and total>8: emit full word with out_last=0; remainder (total-8 bytes) goes to hold; go to FLUSH.
- FLUSH: in_ready=0. When free, emit hold with out_bytes=fill and out_last=1; fill=0; go to RUN.
- in_bytes=0 without in_last: accepted, no state change.
- Hold lanes at or above fill are always zeroed, so partial outputs carry zeros in unused lanes.

## Timing
- Reset values: fill=0, state RUN, hold=0. Outputs: out_valid=0, out_data=0, out_bytes=0, out_last=0, aln_start=0.
- `in_ready` comes up combinationally in the first cycle after reset deassertion.
- Latency: a word completed by the chunk accepted in cycle N has out_valid=1 in cycle N+1.
- Throughput: one chunk per cycle while out_ready=1. The only bubble is the single FLUSH cycle after a last chunk with total>8.
- Backpressure: while out_valid & !out_ready, out_* hold stable and in_ready=0. Accept and drain may occur in the same cycle.
- aln_start/aln_in are combinational from fill/in_data. aln_out is sampled at the accepting edge only.
- Reset mid-operation (including FLUSH) discards hold and any pending output word immediately.

## Test plan
- Four 8-byte chunks, out_ready=1: aln_start=0 throughout. Each word appears unchanged one cycle after acceptance with out_bytes=8; the fourth carries in_last and gives out_last=1.
- 3-byte chunk 64'hAABBCC, then 8-byte chunk 64'h0123456789ABCDEF: aln_start=3 on the second chunk. out_data=64'h6789ABCDEFAABBCC, out_bytes=8, fill=3. Then in_bytes=0 with in_last gives out_data=64'h0000000000012345, out_bytes=3, out_last=1.
- fill=5, then a 6-byte last chunk: a full word with out_last=0 appears, in_ready=0 for one cycle, then a 3-byte word with out_last=1, then back to RUN.
- out_ready held 0 for 5 cycles with a pending word: out_data stable and in_ready=0 throughout. On release, the pending word drains and the next chunk is accepted in the same cycle.
- rst asserted during FLUSH: out_valid=0 and fill=0 at once. After release, an 8-byte chunk passes through with aln_start=0.
- in_bytes=12 on a single chunk: treated as 8 bytes, giving out_bytes=8 and unchanged fill.

Source files
------------

// File: rtl/alignment_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alignment_sequencer
// Description : Packs variable-length, low-justified chunks into dense 8-byte
//               words by steering an external byte-rotation network.
// Revision    : 1.0 - initial release
// ============================================================================
module alignment_sequencer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [3:0]            in_bytes,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] aln_in,
    output logic                  aln_reverse,
    output logic [2:0]            aln_start,
    input  logic [DATA_WIDTH-1:0] aln_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            out_bytes,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                r_state, w_stateNext;
    logic [2:0]            r_fill, w_fillNext;
    logic [DATA_WIDTH-1:0] r_hold, w_holdNext;
    logic [DATA_WIDTH-1:0] r_outData, w_outDataNext;
    logic [3:0]            r_outBytes, w_outBytesNext;
    logic                  r_outLast, w_outLastNext;
    logic                  r_outValid, w_outValidNext;

    logic                  w_free;
    logic                  w_accept;
    logic [3:0]            w_n;
    logic [3:0]            w_total;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_remain;

    assign w_free   = !r_outValid || out_ready;
    assign in_ready = (r_state == RUN) && w_free;
    assign w_accept = in_valid && in_ready;

    assign w_n     = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign w_total = {1'b0, r_fill} + w_n;

    assign aln_in      = in_data;
    assign aln_reverse = 1'b0;
    assign aln_start   = r_fill;

    // Per lane: held byte below fill, rotated chunk byte up to total, else zero.
    // Rotated lanes that wrapped past lane 7 form the carry-over hold.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        localparam logic [3:0] c_LANE = 4'(k);
        assign w_merged[8*k +: 8] = (c_LANE < {1'b0, r_fill}) ? r_hold[8*k +: 8] :
                                    (c_LANE < w_total)        ? aln_out[8*k +: 8] : 8'h00;
        assign w_remain[8*k +: 8] = ((c_LANE + 4'd8) < w_total) ? aln_out[8*k +: 8] : 8'h00;
    end

    always_comb begin
        w_stateNext    = r_state;
        w_fillNext     = r_fill;
        w_holdNext     = r_hold;
        w_outDataNext  = r_outData;
        w_outBytesNext = r_outBytes;
        w_outLastNext  = r_outLast;
        w_outValidNext = r_outValid && !out_ready;

        if (r_state == FLUSH) begin
            if (w_free) begin
                w_outValidNext = 1'b1;
                w_outDataNext  = r_hold;
                w_outBytesNext = {1'b0, r_fill};
                w_outLastNext  = 1'b1;
                w_fillNext     = 3'd0;
                w_holdNext     = '0;
                w_stateNext    = RUN;
            end
        end else if (w_accept) begin
            if (in_last && (w_total <= 4'd8)) begin
                if (w_total != 4'd0) begin
                    w_outValidNext = 1'b1;
                    w_outDataNext  = w_merged;
                    w_outBytesNext = w_total;
                    w_outLastNext  = 1'b1;
                end
                w_fillNext = 3'd0;
                w_holdNext = '0;
            end else if (w_total >= 4'd8) begin
                w_outValidNext = 1'b1;
                w_outDataNext  = w_merged;
                w_outBytesNext = 4'd8;
                w_outLastNext  = 1'b0;
                w_holdNext     = w_remain;
                w_fillNext     = w_total[2:0];
                // A last chunk reaching here overflowed the word; its tail needs its own beat.
                if (in_last) begin
                    w_stateNext = FLUSH;
                end
            end else begin
                w_holdNext = w_merged;
                w_fillNext = w_total[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_fill     <= 3'd0;
            r_hold     <= '0;
            r_outData  <= '0;
            r_outBytes <= 4'd0;
            r_outLast  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_fill     <= w_fillNext;
            r_hold     <= w_holdNext;
            r_outData  <= w_outDataNext;
            r_outBytes <= w_outBytesNext;
            r_outLast  <= w_outLastNext;
            r_outValid <= w_outValidNext;
        end
    end

    assign out_data  = r_outData;
    assign out_bytes = r_outBytes;
    assign out_last  = r_outLast;
    assign out_valid = r_outValid;

endmodule
`default_nettype wire

// File: tb/tb_alignment_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alignment_sequencer
// Description : Directed self-checking bench with a behavioural rotation network.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alignment_sequencer;

    logic        clk;
    logic        rst;
    logic [63:0] inData;
    logic [3:0]  inBytes;
    logic        inLast;
    logic        inValid;
    logic        inReady;
    logic [63:0] alnIn;
    logic        alnReverse;
    logic [2:0]  alnStart;
    logic [63:0] alnOut;
    logic [63:0] outData;
    logic [3:0]  outBytes;
    logic        outLast;
    logic        outValid;
    logic        outReady;

    int nAssert = 0;
    int nFail   = 0;

    alignment_sequencer #(.DATA_WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (inData),
        .in_bytes   (inBytes),
        .in_last    (inLast),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .aln_in     (alnIn),
        .aln_reverse(alnReverse),
        .aln_start  (alnStart),
        .aln_out    (alnOut),
        .out_data   (outData),
        .out_bytes  (outBytes),
        .out_last   (outLast),
        .out_valid  (outValid),
        .out_ready  (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Network model: output byte k takes input byte (k - start) mod 8.
    always_comb begin
        alnOut = '0;
        for (int k = 0; k < 8; k++) begin
            alnOut[8*k +: 8] = alnIn[8*((k - int'(alnStart)) & 7) +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [3:0] b, input logic l, input logic v);
        inData  = d;
        inBytes = b;
        inLast  = l;
        inValid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] words [4];

    initial begin
        words[0] = 64'h1122334455667788;
        words[1] = 64'h99AABBCCDDEEFF00;
        words[2] = 64'hCAFEBABEDEADBEEF;
        words[3] = 64'h0F1E2D3C4B5A6978;

        rst      = 1'b1;
        outReady = 1'b1;
        drive(64'h0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_out_valid", {63'b0, outValid}, 64'd0);
        check("rst_out_data", outData, 64'd0);
        check("rst_out_bytes", {60'b0, outBytes}, 64'd0);
        check("rst_out_last", {63'b0, outLast}, 64'd0);
        check("rst_aln_start", {61'b0, alnStart}, 64'd0);
        check("rst_aln_reverse", {63'b0, alnReverse}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'b0, inReady}, 64'd1);

        // Full-width passthrough
        for (int i = 0; i < 4; i++) begin
            drive(words[i], 4'd8, (i == 3), 1'b1);
            #1;
            check("pass_aln_start", {61'b0, alnStart}, 64'd0);
            check("pass_aln_in", alnIn, words[i]);
            tick();
            check("pass_out_valid", {63'b0, outValid}, 64'd1);
            check("pass_out_data", outData, words[i]);
            check("pass_out_bytes", {60'b0, outBytes}, 64'd8);
            check("pass_out_last", {63'b0, outLast}, (i == 3) ? 64'd1 : 64'd0);
        end
        drive(64'h0, 4'd0, 1'b0, 1'b0);
        tick();
        check("pass_idle_valid", {63'b0, outValid}, 64'd0);

        // 3 + 8 bytes, then an empty last chunk flushes the remainder
        drive(64'h0000000000AABBCC, 4'd3, 1'b0, 1'b1);
        tick();
        check("p3_no_out", {63'b0, outValid}, 64'd0);
        drive(64'h0123456789ABCDEF, 4'd8, 1'b0, 1'b1);
        #1;
        check("p3_aln_start", {61'b0, alnStart}, 64'd3);
        tick();
        check("p3_out_data", outData, 64'h6789ABCDEFAABBCC);
        check("p3_out_bytes", {60'b0, outBytes}, 64'd8);
        check("p3_out_last", {63'b0, outLast}, 64'd0);
        check("p3_fill", {61'b0, alnStart}, 64'd3);
        drive(64'h0, 4'd0, 1'b1, 1'b1);
        tick();
        check("p3_flush_data", outData, 64'h0000000000012345);
        check("p3_flush_bytes", {60'b0, outBytes}, 64'd3);
        check("p3_flush_last", {63'b0, outLast}, 64'd1);
        check("p3_fill_zero", {61'b0, alnStart}, 64'd0);
        drive(64'h0, 4'd0, 1'b0, 1'b0);
        tick();

        // fill=5, then a 6-byte last chunk overflows into a FLUSH beat
        drive(64'h0000001122334455, 4'd5, 1'b0, 1'b1);
        tick();
        check("ovf_fill5", {61'b0, alnStart}, 64'd5);
        drive(64'h0000A1A2A3A4A5A6, 4'd6, 1'b1, 1'b1);
        tick();
        check("ovf_word_data", outData, 64'hA4A5A61122334455);
        check("ovf_word_bytes", {60'b0, outBytes}, 64'd8);
        check("ovf_word_last", {63'b0, outLast}, 64'd0);
        check("ovf_flush_ready", {63'b0, inReady}, 64'd0);
        drive(64'hFFFFFFFFFFFFFFFF, 4'd8, 1'b0, 1'b1);
        tick();
        check("ovf_tail_data", outData, 64'h0000000000A1A2A3);
        check("ovf_tail_bytes", {60'b0, outBytes}, 64'd3);
        check("ovf_tail_last", {63'b0, outLast}, 64'd1);
        check("ovf_run_ready", {63'b0, inReady}, 64'd1);
        check("ovf_fill_zero", {61'b0, alnStart}, 64'd0);
        drive(64'h0, 4'd0, 1'b0, 1'b0);
        tick();

        // Backpressure
        outReady = 1'b0;
        drive(64'h1111111111111111, 4'd8, 1'b0, 1'b1);
        tick();
        drive(64'h2222222222222222, 4'd8, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_data", outData, 64'h1111111111111111);
            check("bp_out_valid", {63'b0, outValid}, 64'd1);
            check("bp_in_ready", {63'b0, inReady}, 64'd0);
            tick();
        end
        outReady = 1'b1;
        #1;
        check("bp_release_ready", {63'b0, inReady}, 64'd1);
        tick();
        check("bp_next_data", outData, 64'h2222222222222222);
        check("bp_next_valid", {63'b0, outValid}, 64'd1);
        drive(64'h0, 4'd0, 1'b0, 1'b0);
        tick();
        check("bp_drained", {63'b0, outValid}, 64'd0);

        // Reset while in FLUSH
        drive(64'h0000001122334455, 4'd5, 1'b0, 1'b1);
        tick();
        drive(64'h0000A1A2A3A4A5A6, 4'd6, 1'b1, 1'b1);
        tick();
        drive(64'h0, 4'd0, 1'b0, 1'b0);
        check("rf_in_flush", {63'b0, inReady}, 64'd0);
        rst = 1'b1;
        #1;
        check("rf_out_valid", {63'b0, outValid}, 64'd0);
        check("rf_fill", {61'b0, alnStart}, 64'd0);
        tick();
        rst = 1'b0;
        drive(64'hDEADBEEFCAFEF00D, 4'd8, 1'b0, 1'b1);
        #1;
        check("rf_aln_start", {61'b0, alnStart}, 64'd0);
        tick();
        check("rf_out_data", outData, 64'hDEADBEEFCAFEF00D);
        check("rf_out_bytes", {60'b0, outBytes}, 64'd8);

        // Oversized byte count clamps to 8
        drive(64'h0102030405060708, 4'd12, 1'b0, 1'b1);
        tick();
        check("clamp_out_data", outData, 64'h0102030405060708);
        check("clamp_out_bytes", {60'b0, outBytes}, 64'd8);
        check("clamp_fill", {61'b0, alnStart}, 64'd0);
        drive(64'h0000000000C3C2C1, 4'd3, 1'b0, 1'b1);
        tick();
        drive(64'h0102030405060708, 4'd12, 1'b0, 1'b1);
        tick();
        check("clamp3_out_data", outData, 64'h0405060708C3C2C1);
        check("clamp3_out_bytes", {60'b0, outBytes}, 64'd8);
        check("clamp3_fill", {61'b0, alnStart}, 64'd3);
        drive(64'h0, 4'd0, 1'b1, 1'b1);
        tick();
        check("clamp3_tail_data", outData, 64'h0000000000010203);
        check("clamp3_tail_bytes", {60'b0, outBytes}, 64'd3);
        check("clamp3_tail_last", {63'b0, outLast}, 64'd1);
        drive(64'h0, 4'd0, 1'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
